// File: rtl/sync_fifo_pkt.sv
// sync_fifo_pkt: single-clock FIFO with packet commit/discard, fill level,
// programmable almost-full/almost-empty flags and FWFT or registered read.
// Writes land behind a speculative pointer and become visible to the reader
// only when the committed pointer catches up with it, so a half-captured
// frame can be thrown away without disturbing data already handed over.

module sync_fifo_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 1,
    parameter int PKT_MODE   = 1,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr_commit,
    input  logic                  wr_discard,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] ONE       = PW'(1);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

    // Storage array; contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra MSB so that full and empty are distinguishable.
    logic [PW-1:0] wptr_spec_q, wptr_spec_d;
    logic [PW-1:0] wptr_cmt_q,  wptr_cmt_d;
    logic [PW-1:0] rptr_q,      rptr_d;

    // Registered status, all computed from the next-state pointers.
    logic [PW-1:0] level_q, level_d;
    logic          full_q,         full_d;
    logic          almost_full_q,  almost_full_d;
    logic          empty_q,        empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q,     overflow_d;
    logic          underflow_q,    underflow_d;

    // Registered read path, only meaningful when FWFT is off.
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic [PW-1:0]         spec_count_d;
    logic [DATA_WIDTH-1:0] head_data;

    // Requests are qualified only by registered flags, so a write never sees
    // space freed by a pop in the same cycle and vice versa.
    assign wr_accept = wr_en && !full_q;
    assign rd_accept = rd_en && !empty_q;
    assign head_data = mem[rptr_q[ADDR_WIDTH-1:0]];

    // Next-state pointers: write, commit/discard, then pop.
    always_comb begin
        wptr_spec_d = wptr_spec_q;
        wptr_cmt_d  = wptr_cmt_q;
        rptr_d      = rptr_q;

        if (wr_accept) begin
            wptr_spec_d = wptr_spec_q + ONE;
        end

        if (PKT_MODE != 0) begin
            // Discard rewinds past any write in this same cycle and beats a
            // simultaneous commit; commit includes this cycle's write.
            if (wr_discard) begin
                wptr_spec_d = wptr_cmt_q;
            end else if (wr_commit) begin
                wptr_cmt_d = wptr_spec_d;
            end
        end else begin
            wptr_cmt_d = wptr_spec_d;
        end

        if (rd_accept) begin
            rptr_d = rptr_q + ONE;
        end
    end

    // Next-state flags, level and registered read data.
    always_comb begin
        spec_count_d   = wptr_spec_d - rptr_d;
        level_d        = wptr_cmt_d - rptr_d;
        full_d         = (spec_count_d == DEPTH_CNT);
        almost_full_d  = (spec_count_d >= AF_CNT);
        empty_d        = (wptr_cmt_d == rptr_d);
        almost_empty_d = (level_d <= AE_CNT);
        overflow_d     = wr_en && full_q;
        underflow_d    = rd_en && empty_q;
        rvalid_d       = 1'b0;
        rdata_d        = rdata_q;

        if ((FWFT == 0) && rd_accept) begin
            rvalid_d = 1'b1;
            rdata_d  = head_data;
        end
    end

    // State register with asynchronous reset; a reset drops every packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_spec_q    <= '0;
            wptr_cmt_q     <= '0;
            rptr_q         <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
        end else begin
            wptr_spec_q    <= wptr_spec_d;
            wptr_cmt_q     <= wptr_cmt_d;
            rptr_q         <= rptr_d;
            level_q        <= level_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
        end
    end

    // Memory write port; the slot is always free because full gates it.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_spec_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign underflow    = underflow_q;
    assign level        = level_q;
    assign rdata        = (FWFT != 0) ? head_data : rdata_q;
    assign rvalid       = (FWFT != 0) ? !empty_q  : rvalid_q;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// tb_sync_fifo_pkt: drives three FIFO flavours (stream/FWFT, packet/FWFT,
// stream/registered read) one at a time against a queue-based model.

module tb_sync_fifo_pkt;

    logic       clk;
    logic       rst;
    logic [2:0] wr_en, wr_commit, wr_discard, rd_en;
    logic [7:0] wdata [3];
    logic [2:0] full, almost_full, overflow, rvalid, empty, almost_empty, underflow;
    logic [7:0] rdata [3];
    logic [4:0] level [3];

    int checks   = 0;
    int failures = 0;

    // Reference model: speculative and committed contents of the active FIFO.
    logic [7:0] model_spec [$];
    logic [7:0] model_cmt  [$];
    logic [7:0] last_rd;

    typedef struct {
        bit         we;
        logic [7:0] wd;
        bit         cm;
        bit         re;
        int         lvl;
        bit         fl;
        bit         af;
        bit         em;
        bit         ov;
    } vec_t;

    vec_t vecs [$];

    // Instance 0: stream + FWFT, 1: packet + FWFT, 2: stream + registered read.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sync_fifo_pkt #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (4),
            .FWFT       ((g == 2) ? 0 : 1),
            .PKT_MODE   ((g == 1) ? 1 : 0),
            .AF_LEVEL   (14),
            .AE_LEVEL   (2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[g]),
            .wdata        (wdata[g]),
            .wr_commit    (wr_commit[g]),
            .wr_discard   (wr_discard[g]),
            .full         (full[g]),
            .almost_full  (almost_full[g]),
            .overflow     (overflow[g]),
            .rd_en        (rd_en[g]),
            .rdata        (rdata[g]),
            .rvalid       (rvalid[g]),
            .empty        (empty[g]),
            .almost_empty (almost_empty[g]),
            .underflow    (underflow[g]),
            .level        (level[g])
        );
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        wr_en      = '0;
        wr_commit  = '0;
        wr_discard = '0;
        rd_en      = '0;
        for (int i = 0; i < 3; i++) wdata[i] = 8'h00;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_spec.delete();
        model_cmt.delete();
        last_rd = 8'h00;
        for (int u = 0; u < 3; u++) begin
            checkOutput("rst_level", level[u], 0);
            checkOutput("rst_empty", empty[u], 1);
            checkOutput("rst_ae", almost_empty[u], 1);
            checkOutput("rst_full", full[u], 0);
            checkOutput("rst_af", almost_full[u], 0);
            checkOutput("rst_ovf", overflow[u], 0);
            checkOutput("rst_unf", underflow[u], 0);
            checkOutput("rst_rvalid", rvalid[u], 0);
        end
        checkOutput("rst_rdata", rdata[2], 8'h00);
    endtask

    // One clock of stimulus on instance u, scored against the model.
    task automatic applyStimulus(input int u, input bit we, input logic [7:0] wd,
                                 input bit cm, input bit dc, input bit re);
        bit         fwft, pkt, full_m, empty_m, wr_acc, rd_acc;
        logic [7:0] popped;
        fwft    = (u != 2);
        pkt     = (u == 1);
        full_m  = (model_cmt.size() + model_spec.size()) == 16;
        empty_m = (model_cmt.size() == 0);
        wr_acc  = we && !full_m;
        rd_acc  = re && !empty_m;
        popped  = 8'h00;
        if (fwft && !empty_m) checkOutput("head_data", rdata[u], model_cmt[0]);

        wr_en[u]      = we;
        wdata[u]      = wd;
        wr_commit[u]  = cm;
        wr_discard[u] = dc;
        rd_en[u]      = re;

        if (rd_acc) popped = model_cmt.pop_front();
        if (wr_acc) begin
            if (pkt) model_spec.push_back(wd);
            else     model_cmt.push_back(wd);
        end
        if (pkt) begin
            if (dc) model_spec.delete();
            else if (cm) while (model_spec.size() > 0) model_cmt.push_back(model_spec.pop_front());
        end

        @(posedge clk);
        #1;
        clearInputs();

        checkOutput("level", level[u], model_cmt.size());
        checkOutput("empty", empty[u], model_cmt.size() == 0);
        checkOutput("full", full[u], (model_cmt.size() + model_spec.size()) == 16);
        checkOutput("almost_full", almost_full[u], (model_cmt.size() + model_spec.size()) >= 14);
        checkOutput("almost_empty", almost_empty[u], model_cmt.size() <= 2);
        checkOutput("overflow", overflow[u], we && full_m);
        checkOutput("underflow", underflow[u], re && empty_m);
        if (fwft) begin
            checkOutput("rvalid_fwft", rvalid[u], model_cmt.size() != 0);
        end else begin
            checkOutput("rvalid_reg", rvalid[u], rd_acc);
            if (rd_acc) last_rd = popped;
            checkOutput("rdata_reg", rdata[u], last_rd);
        end
    endtask

    task automatic runTable(input int u);
        foreach (vecs[i]) begin
            applyStimulus(u, vecs[i].we, vecs[i].wd, vecs[i].cm, 1'b0, vecs[i].re);
            checkOutput("tbl_level", level[u], vecs[i].lvl);
            checkOutput("tbl_full", full[u], vecs[i].fl);
            checkOutput("tbl_af", almost_full[u], vecs[i].af);
            checkOutput("tbl_empty", empty[u], vecs[i].em);
            checkOutput("tbl_ovf", overflow[u], vecs[i].ov);
        end
    endtask

    function automatic vec_t mkv(bit we, logic [7:0] wd, bit cm, bit re,
                                 int lvl, bit fl, bit af, bit em, bit ov);
        vec_t v;
        v.we = we; v.wd = wd; v.cm = cm; v.re = re;
        v.lvl = lvl; v.fl = fl; v.af = af; v.em = em; v.ov = ov;
        return v;
    endfunction

    // Main sequence.
    initial begin
        logic [7:0] order [4];
        rst = 1'b1;
        clearInputs();
        last_rd = 8'h00;

        // Stream mode fill, overflow and drain on instance 0.
        doReset();
        vecs.delete();
        for (int i = 0; i < 16; i++)
            vecs.push_back(mkv(1, 8'(i + 1), 0, 0, i + 1, i == 15, (i + 1) >= 14, 0, 0));
        vecs.push_back(mkv(1, 8'hEE, 0, 0, 16, 1, 1, 0, 1));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mkv(0, 8'h00, 0, 1, 15 - i, 0, (15 - i) >= 14, i == 15, 0));
        runTable(0);

        // Packet mode: data invisible until commit on instance 1.
        doReset();
        vecs.delete();
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(1, 8'(8'hA0 + i), 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 1, 0, 5, 0, 0, 0, 0));
        runTable(1);
        checkOutput("commit_head", rdata[1], 8'hA0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'h00, 0, 0, 1);

        // Uncommitted data alone can fill the FIFO; discard frees it.
        for (int i = 0; i < 16; i++) applyStimulus(1, 1, 8'(8'hC0 + i), 0, 0, 0);
        checkOutput("spec_full", full[1], 1);
        checkOutput("spec_full_level", level[1], 0);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("discard_full", full[1], 0);
        checkOutput("discard_af", almost_full[1], 0);

        // Commit, then discard with a same-cycle write, then a new packet.
        doReset();
        applyStimulus(1, 1, 8'h11, 0, 0, 0);
        applyStimulus(1, 1, 8'h12, 0, 0, 0);
        applyStimulus(1, 1, 8'h13, 1, 0, 0);
        checkOutput("commit3_level", level[1], 3);
        applyStimulus(1, 1, 8'h21, 0, 0, 0);
        applyStimulus(1, 1, 8'h22, 0, 0, 0);
        applyStimulus(1, 1, 8'h23, 1, 1, 0);
        checkOutput("discard_level", level[1], 3);
        applyStimulus(1, 1, 8'h31, 1, 0, 0);
        order[0] = 8'h11; order[1] = 8'h12; order[2] = 8'h13; order[3] = 8'h31;
        for (int k = 0; k < 4; k++) begin
            checkOutput("pkt_order", rdata[1], order[k]);
            applyStimulus(1, 0, 8'h00, 0, 0, 1);
        end
        checkOutput("pkt_drained", empty[1], 1);

        // Registered read path on instance 2.
        doReset();
        applyStimulus(2, 1, 8'h55, 0, 0, 0);
        applyStimulus(2, 1, 8'h66, 0, 0, 0);
        checkOutput("reg_level2", level[2], 2);
        checkOutput("reg_no_rvalid", rvalid[2], 0);
        applyStimulus(2, 0, 8'h00, 0, 0, 1);
        checkOutput("reg_rvalid1", rvalid[2], 1);
        checkOutput("reg_rdata1", rdata[2], 8'h55);
        applyStimulus(2, 0, 8'h00, 0, 0, 1);
        checkOutput("reg_rvalid2", rvalid[2], 1);
        checkOutput("reg_rdata2", rdata[2], 8'h66);
        applyStimulus(2, 0, 8'h00, 0, 0, 0);
        checkOutput("reg_hold", rdata[2], 8'h66);
        applyStimulus(2, 0, 8'h00, 0, 0, 1);
        checkOutput("reg_underflow", underflow[2], 1);
        checkOutput("reg_unf_rvalid", rvalid[2], 0);

        // Wrap-around streaming and simultaneous write/pop at the boundaries.
        doReset();
        applyStimulus(0, 1, 8'h80, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0, 1);
            checkOutput("wrap_level", level[0], 1);
        end
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 8'(8'h90 + i), 0, 0, 0);
        checkOutput("wrap_full", full[0], 1);
        applyStimulus(0, 1, 8'hEE, 0, 0, 1);
        checkOutput("full_wp_ovf", overflow[0], 1);
        checkOutput("full_wp_level", level[0], 15);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("drained", empty[0], 1);
        applyStimulus(0, 1, 8'h42, 0, 0, 1);
        checkOutput("empty_wp_unf", underflow[0], 1);
        checkOutput("empty_wp_level", level[0], 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);

        // Asynchronous reset between edges with committed and speculative data.
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 8'(8'h60 + i), i == 6, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'(8'h70 + i), 0, 0, 0);
        checkOutput("pre_rst_level", level[1], 7);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_level", level[1], 0);
        checkOutput("async_empty", empty[1], 1);
        checkOutput("async_ae", almost_empty[1], 1);
        checkOutput("async_full", full[1], 0);
        checkOutput("async_rvalid", rvalid[1], 0);
        model_spec.delete();
        model_cmt.delete();
        last_rd = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 1, 8'h77, 1, 0, 0);
        checkOutput("post_rst_head", rdata[1], 8'h77);
        applyStimulus(1, 0, 8'h00, 0, 0, 1);
        checkOutput("post_rst_empty", empty[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
